// File: rtl/dyn_scan_ctrl.sv
// Multiplexed 7-segment scan controller: refresh divider, digit counter, hex decode,
// per-digit masking and selectable polarity. Optional blanking interval: DYN_SCAN_GHOST_BLANK_EN.
module dyn_scan_ctrl #(
  parameter int DIGITS         = 6,
  parameter int CLK_DIV        = 50000,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int BLANK_CYCLES   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     digit_en,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            seg,
  output logic                  frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIGITS-1:0] SEL_IDLE = (SEL_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [7:0] SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
`ifdef DYN_SCAN_GHOST_BLANK_EN
  localparam bit GHOST_EN = 1'b1;
`else
  localparam bit GHOST_EN = 1'b0;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      4'hF: code = 7'h71;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic [3:0]        nib_s;
  logic              dp_s;
  logic              den_s;
  logic              blank_s;
  logic              show_s;
  logic [DIGITS-1:0] sel_oh_s;
  logic [7:0]        seg_lit_s;
  logic [DIGITS-1:0] sel_nxt_s;
  logic [7:0]        seg_nxt_s;

  // Slot divider and digit index; a disabled scan is parked at digit 0, slot start.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= {IDX_W{1'b0}};
    end else if (cnt_r == CNT_W'(CLK_DIV - 1)) begin
      cnt_r <= {CNT_W{1'b0}};
      idx_r <= (idx_r == IDX_W'(DIGITS - 1)) ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      idx_r <= idx_r;
    end
  end

  // Per-digit input selection, masking and polarity of the next output word.
  always_comb begin
    nib_s = 4'h0;
    dp_s  = 1'b0;
    den_s = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      nib_s = (idx_r == IDX_W'(i)) ? digit_data[4*i +: 4] : nib_s;
      dp_s  = (idx_r == IDX_W'(i)) ? dp_in[i]             : dp_s;
      den_s = (idx_r == IDX_W'(i)) ? digit_en[i]          : den_s;
    end
    blank_s   = GHOST_EN && (cnt_r < CNT_W'(BLANK_CYCLES));
    show_s    = en && den_s && !blank_s;
    sel_oh_s  = DIGITS'(1) << idx_r;
    seg_lit_s = {dp_s, hex7(nib_s)};
    if (!show_s) begin
      sel_nxt_s = SEL_IDLE;
      seg_nxt_s = SEG_BLANK;
    end else begin
      sel_nxt_s = (SEL_ACTIVE_LOW != 0) ? ~sel_oh_s : sel_oh_s;
      seg_nxt_s = (SEG_ACTIVE_LOW != 0) ? ~seg_lit_s : seg_lit_s;
    end
  end

  // Output register; the tick marks the cycle digit 0 of a new frame is first presented.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel        <= SEL_IDLE;
      seg        <= SEG_BLANK;
      frame_tick <= 1'b0;
    end else begin
      sel        <= sel_nxt_s;
      seg        <= seg_nxt_s;
      frame_tick <= en && (cnt_r == {CNT_W{1'b0}}) && (idx_r == {IDX_W{1'b0}});
    end
  end

endmodule

// File: tb/tb_dyn_scan_ctrl.sv
// Directed self-checking bench for dyn_scan_ctrl: three instances cover the main
// 6-digit configuration, the 1-digit inverted-polarity edge and the blanking configuration.
module tb_dyn_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst;
  logic        en0, en1, en2;
  logic [23:0] data0;
  logic [5:0]  dp0, den0;
  logic [5:0]  sel0, sel2;
  logic [7:0]  seg0, seg2;
  logic        tick0, tick2;
  logic [3:0]  data1;
  logic [0:0]  dp1, den1, sel1;
  logic [7:0]  seg1;
  logic        tick1;

  logic [5:0] sel_tab [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [7:0] seg_tab [6] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D};
  logic [5:0] msel_tab[6] = '{6'h3E, 6'h3F, 6'h3B, 6'h37, 6'h3F, 6'h1F};
  logic [7:0] mseg_tab[6] = '{8'h77, 8'h00, 8'hB9, 8'h5E, 8'h00, 8'h71};

  dyn_scan_ctrl #(.DIGITS(6), .CLK_DIV(4), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0), .BLANK_CYCLES(1)) u_main (
    .clk(clk), .rst(rst), .en(en0), .digit_data(data0), .dp_in(dp0), .digit_en(den0),
    .sel(sel0), .seg(seg0), .frame_tick(tick0));

  dyn_scan_ctrl #(.DIGITS(1), .CLK_DIV(2), .SEL_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1), .BLANK_CYCLES(1)) u_edge (
    .clk(clk), .rst(rst), .en(en1), .digit_data(data1), .dp_in(dp1), .digit_en(den1),
    .sel(sel1), .seg(seg1), .frame_tick(tick1));

  dyn_scan_ctrl #(.DIGITS(6), .CLK_DIV(8), .SEL_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0), .BLANK_CYCLES(3)) u_ghost (
    .clk(clk), .rst(rst), .en(en2), .digit_data(data0), .dp_in(dp0), .digit_en(den0),
    .sel(sel2), .seg(seg2), .frame_tick(tick2));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart0();
    en0 = 1'b0;
    step();
    step();
    en0 = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
    data0 = 24'h543210; dp0 = 6'h00; den0 = 6'h3F;
    data1 = 4'h8; dp1 = 1'b0; den1 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (sel0 !== 6'h3F || seg0 !== 8'h00 || tick0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_main cyc=%0d got sel=%h seg=%h tick=%b exp sel=3f seg=00 tick=0", c, sel0, seg0, tick0);
      end
      checks++;
      if (sel1 !== 1'b0 || seg1 !== 8'hFF) begin
        errors++;
        $display("FAIL reset_edge cyc=%0d got sel=%h seg=%h exp sel=0 seg=ff", c, sel1, seg1);
      end
    end
    rst = 1'b0;
    en0 = 1'b1;
  endtask

  task automatic test_scan();
    for (int c = 0; c < 25; c++) begin
      step();
      checks++;
      if (sel0 !== sel_tab[(c/4)%6] || seg0 !== seg_tab[(c/4)%6]) begin
        errors++;
        $display("FAIL scan cyc=%0d got sel=%h seg=%h exp sel=%h seg=%h", c, sel0, seg0, sel_tab[(c/4)%6], seg_tab[(c/4)%6]);
      end
    end
  endtask

  task automatic test_frame_tick();
    int pulses = 0;
    restart0();
    for (int c = 0; c < 72; c++) begin
      step();
      if (tick0 === 1'b1) pulses++;
      checks++;
      if (tick0 !== (c % 24 == 0)) begin
        errors++;
        $display("FAIL frame_tick cyc=%0d got=%b exp=%b", c, tick0, (c % 24 == 0));
      end
      if (c % 24 == 0) begin
        checks++;
        if (sel0 !== 6'h3E) begin
          errors++;
          $display("FAIL tick_sel cyc=%0d got sel=%h exp sel=3e", c, sel0);
        end
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL tick_count got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_mask();
    den0 = 6'b101101; dp0 = 6'b000100; data0 = 24'hFEDCBA;
    restart0();
    for (int c = 0; c < 24; c++) begin
      step();
      checks++;
      if (sel0 !== msel_tab[c/4] || seg0 !== mseg_tab[c/4]) begin
        errors++;
        $display("FAIL mask cyc=%0d got sel=%h seg=%h exp sel=%h seg=%h", c, sel0, seg0, msel_tab[c/4], mseg_tab[c/4]);
      end
    end
    den0 = 6'h3F; dp0 = 6'h00; data0 = 24'h543210;
  endtask

  // use_rst=0 interrupts with en low, use_rst=1 with rst high
  task automatic test_interrupt(input bit use_rst);
    restart0();
    for (int c = 0; c < 14; c++) step();
    checks++;
    if (sel0 !== 6'h37) begin
      errors++;
      $display("FAIL intr_pre rst=%0d got sel=%h exp sel=37", use_rst, sel0);
    end
    if (use_rst) rst = 1'b1; else en0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (sel0 !== 6'h3F || seg0 !== 8'h00 || tick0 !== 1'b0) begin
        errors++;
        $display("FAIL intr_idle rst=%0d cyc=%0d got sel=%h seg=%h tick=%b exp 3f/00/0", use_rst, c, sel0, seg0, tick0);
      end
    end
    rst = 1'b0;
    en0 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (sel0 !== sel_tab[c/4] || seg0 !== seg_tab[c/4] || tick0 !== (c == 0)) begin
        errors++;
        $display("FAIL intr_restart rst=%0d cyc=%0d got sel=%h seg=%h tick=%b exp sel=%h seg=%h tick=%b",
                 use_rst, c, sel0, seg0, tick0, sel_tab[c/4], seg_tab[c/4], (c == 0));
      end
    end
  endtask

  task automatic test_polarity();
    en1 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (sel1 !== 1'b1 || seg1 !== 8'h80 || tick1 !== (c % 2 == 0)) begin
        errors++;
        $display("FAIL polarity cyc=%0d got sel=%h seg=%h tick=%b exp sel=1 seg=80 tick=%b", c, sel1, seg1, tick1, (c % 2 == 0));
      end
    end
    en1 = 1'b0;
    step();
    checks++;
    if (sel1 !== 1'b0 || seg1 !== 8'hFF || tick1 !== 1'b0) begin
      errors++;
      $display("FAIL polarity_off got sel=%h seg=%h tick=%b exp sel=0 seg=ff tick=0", sel1, seg1, tick1);
    end
  endtask

  task automatic test_ghost_blank();
    logic       blank;
    logic [5:0] esel;
    logic [7:0] eseg;
    en2 = 1'b1;
    for (int c = 0; c < 48; c++) begin
      step();
`ifdef DYN_SCAN_GHOST_BLANK_EN
      blank = (c % 8) < 3;
`else
      blank = 1'b0;
`endif
      esel = blank ? 6'h3F : sel_tab[c/8];
      eseg = blank ? 8'h00 : seg_tab[c/8];
      checks++;
      if (sel2 !== esel || seg2 !== eseg || tick2 !== (c == 0)) begin
        errors++;
        $display("FAIL ghost cyc=%0d got sel=%h seg=%h tick=%b exp sel=%h seg=%h tick=%b",
                 c, sel2, seg2, tick2, esel, eseg, (c == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_frame_tick();
    test_mask();
    test_interrupt(1'b0);
    test_interrupt(1'b1);
    test_polarity();
    test_ghost_blank();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
